// File: rtl/ifu_prefetch_if.sv
// Signal bundle between the prefetch unit (master), the IROM and the ID stage (slave side).
// With IFU_PREDECODE_EN defined the bundle also carries the per-instruction id_opc_legal flag.
interface ifu_prefetch_if #(
  parameter int unsigned IROM_AW = 14
);
  logic               irom_en;
  logic [IROM_AW-1:0] irom_addr;
  logic [31:0]        irom_inst;
  logic               id_valid;
  logic               id_ready;
  logic [31:0]        id_inst;
  logic [31:0]        id_pc;
  logic [31:0]        id_pc4;
  logic               redirect;
  logic [31:0]        redirect_pc;
`ifdef IFU_PREDECODE_EN
  logic               id_opc_legal;

  modport master (
    input  irom_inst, id_ready, redirect, redirect_pc,
    output irom_en, irom_addr, id_valid, id_inst, id_pc, id_pc4, id_opc_legal
  );

  modport slave (
    output irom_inst, id_ready, redirect, redirect_pc,
    input  irom_en, irom_addr, id_valid, id_inst, id_pc, id_pc4, id_opc_legal
  );
`else
  modport master (
    input  irom_inst, id_ready, redirect, redirect_pc,
    output irom_en, irom_addr, id_valid, id_inst, id_pc, id_pc4
  );

  modport slave (
    output irom_inst, id_ready, redirect, redirect_pc,
    input  irom_en, irom_addr, id_valid, id_inst, id_pc, id_pc4
  );
`endif
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: sequential IROM reads into a small PC-tagged FIFO that feeds ID.
// IFU_PREDECODE_EN adds a stored opcode-legal bit per FIFO entry, presented as id_opc_legal.
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IROM_AW  = 14
) (
  input  logic           cpu_clk,
  input  logic           cpu_rst,
  ifu_prefetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   reqPc_q, reqPc_d;
  logic          reqVld_q, reqVld_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   memInst_q [DEPTH];
  logic [31:0]   memPc_q   [DEPTH];
`ifdef IFU_PREDECODE_EN
  logic          memLegal_q [DEPTH];
`endif

  logic          headValid;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

`ifdef IFU_PREDECODE_EN
  function automatic logic opcLegal(input logic [6:0] opc);
    case (opc)
      7'b0110011, 7'b0100011, 7'b0010011,
      7'b0110111, 7'b1100011, 7'b0000011,
      7'b1100111, 7'b0010111, 7'b1101111: opcLegal = 1'b1;
      default:                            opcLegal = 1'b0;
    endcase
  endfunction
`endif

  assign headValid    = (count_q != '0);
  assign bus.id_valid = !cpu_rst && headValid;
  assign pop          = bus.id_valid && bus.id_ready && !bus.redirect;
  assign push         = reqVld_q && !bus.redirect;

  // Credit check: words already buffered plus the one in flight, minus the one leaving now.
  assign occupancy    = {1'b0, count_q} + (CW+1)'(reqVld_q) - (CW+1)'(pop);
  assign issue        = !cpu_rst && !bus.redirect && (occupancy < (CW+1)'(DEPTH));

  assign bus.irom_en   = issue;
  assign bus.irom_addr = fetchPc_q[IROM_AW+1:2];

  assign bus.id_inst = cpu_rst ? 32'h0 : memInst_q[rdPtr_q];
  assign bus.id_pc   = cpu_rst ? 32'h0 : memPc_q[rdPtr_q];
  assign bus.id_pc4  = cpu_rst ? 32'h0 : memPc_q[rdPtr_q] + 32'd4;
`ifdef IFU_PREDECODE_EN
  assign bus.id_opc_legal = cpu_rst ? 1'b0 : memLegal_q[rdPtr_q];
`endif

  always_comb begin
    fetchPc_d = fetchPc_q;
    reqPc_d   = reqPc_q;
    reqVld_d  = 1'b0;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    if (bus.redirect) begin
      // The returning word and everything buffered belong to the squashed path.
      fetchPc_d = bus.redirect_pc & ~32'h3;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
    end else begin
      if (issue) begin
        reqPc_d   = fetchPc_q;
        reqVld_d  = 1'b1;
        fetchPc_d = fetchPc_q + 32'd4;
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      fetchPc_q <= RESET_PC;
      reqPc_q   <= '0;
      reqVld_q  <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        memInst_q[i]  <= '0;
        memPc_q[i]    <= '0;
`ifdef IFU_PREDECODE_EN
        memLegal_q[i] <= 1'b0;
`endif
      end
    end else begin
      fetchPc_q <= fetchPc_d;
      reqPc_q   <= reqPc_d;
      reqVld_q  <= reqVld_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      if (push) begin
        memInst_q[wrPtr_q]  <= bus.irom_inst;
        memPc_q[wrPtr_q]    <= reqPc_q;
`ifdef IFU_PREDECODE_EN
        memLegal_q[wrPtr_q] <= opcLegal(bus.irom_inst[6:0]);
`endif
      end
    end
  end
endmodule
